// File: rtl/tcam_array_model.sv
// Behavioural stand-in for the TCAM hard macro: ternary entries with write, read,
// compare and flush, all single-cycle with registered outputs, plus valid-entry occupancy.
module tcam_array_model #(
    parameter int AddressSize = 4,
    parameter int Bits        = 8,
    parameter int Words       = 16,
    parameter int BankSize    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   CS,
    input  logic                   FLUSH,
    input  logic                   VBE,
    input  logic                   DCS,
    input  logic                   WR,
    input  logic                   RD,
    input  logic                   CMP,
    input  logic [Bits-1:0]        DI,
    input  logic [Bits-1:0]        MSKB,
    input  logic                   VBI,
    input  logic [AddressSize-1:0] A,
    input  logic [BankSize-1:0]    CBE,
    output logic [Bits-1:0]        DO,
    output logic                   VBO,
    output logic                   HIT,
    output logic [Words-1:0]       HITLINE,
    output logic [AddressSize:0]   VCNT
);

    localparam int BankWidth = Bits / BankSize;
    localparam logic [AddressSize:0] WordsLimit = (AddressSize + 1)'(Words);

    logic [Bits-1:0]  data_mem [Words];
    logic [Bits-1:0]  mask_mem [Words];
    logic [Words-1:0] valid;
    logic [Bits-1:0]  bit_we;
    logic [Words-1:0] match;
    logic             addr_ok;
    logic             op_flush;
    logic             op_write;
    logic             op_read;
    logic             op_cmp;

    // Fixed-priority decode: only the highest asserted strobe acts in a cycle.
    always_comb begin
        addr_ok  = ({1'b0, A} < WordsLimit);
        op_flush = CS & FLUSH;
        op_write = CS & ~FLUSH & WR;
        op_read  = CS & ~FLUSH & ~WR & RD;
        op_cmp   = CS & ~FLUSH & ~WR & ~RD & CMP;
    end

    // CBE is a per-bank write disable; expand it to a per-bit write enable.
    for (genvar b = 0; b < BankSize; b++) begin : g_bank
        assign bit_we[(b+1)*BankWidth-1 : b*BankWidth] = {BankWidth{~CBE[b]}};
    end

    // A bit only blocks a match where both the search mask and the stored mask care.
    for (genvar i = 0; i < Words; i++) begin : g_match
        assign match[i] = valid[i] &&
                          (((DI ^ data_mem[i]) & MSKB & mask_mem[i]) == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < Words; i++) begin
                data_mem[i] <= '0;
                mask_mem[i] <= '0;
            end
            valid   <= '0;
            DO      <= '0;
            VBO     <= 1'b0;
            HIT     <= 1'b0;
            HITLINE <= '0;
            VCNT    <= '0;
        end else if (op_flush) begin
            valid   <= '0;
            HIT     <= 1'b0;
            HITLINE <= '0;
            VCNT    <= '0;
        end else if (op_write) begin
            if (addr_ok) begin
                if (DCS) begin
                    data_mem[A] <= (data_mem[A] & ~bit_we) | (DI & bit_we);
                    mask_mem[A] <= (mask_mem[A] & ~bit_we) | (MSKB & bit_we);
                end
                if (VBE) begin
                    valid[A] <= VBI;
                    // Occupancy only moves when the valid bit actually changes.
                    if (VBI && !valid[A]) begin
                        VCNT <= VCNT + 1'b1;
                    end else if (!VBI && valid[A]) begin
                        VCNT <= VCNT - 1'b1;
                    end
                end
            end
        end else if (op_read) begin
            DO  <= (DCS && addr_ok) ? data_mem[A] : '0;
            VBO <= (VBE && addr_ok) ? valid[A] : 1'b0;
        end else if (op_cmp) begin
            HITLINE <= match;
            HIT     <= |match;
        end
    end

endmodule
